npu_cmd_dispatch: RTL and testbench

Command dispatcher directly downstream of `spi_slave`. It captures each decoded SPI frame (`cmd`, `tile_i`, `tile_j`, `op_code`, `data_in`) on `valid` and buffers it in a small FIFO. It then issues the frame as a req/ack transaction to the NPU tile array. Read and status results are returned on `data_out`, which feeds `spi_slave` for MISO shift-out on the next frame.

---
 rtl/npu_cmd_dispatch.sv | 215 +++++++++++++++++++++
 tb/tb_npu_cmd_dispatch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_cmd_dispatch.sv
// npu_cmd_dispatch
//
// Buffers decoded SPI frames in a small command FIFO and replays each one as
// a req/ack transaction to the NPU tile array. READ and STATUS results are
// parked on data_out, where spi_slave shifts them out on the next frame.
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   valid          one-cycle pulse per completed SPI frame
//   cmd, tile_i, tile_j, op_code, data_in   decoded frame fields
//   data_out       readback byte for spi_slave
//   tile_req       request to the tile array, held until tile_ack
//   tile_cmd       01 WRITE, 10 READ, 11 EXEC
//   tile_addr      {tile_i, tile_j}
//   tile_op        EXEC opcode
//   tile_wdata     WRITE payload
//   tile_ack       one-cycle completion pulse from the tile array
//   tile_rdata     read data, valid with tile_ack
//   busy           FIFO non-empty or a transaction still in flight
//
// Handshake: tile_req rises the cycle after a WRITE/READ/EXEC is popped and
// stays high, with every tile_* field frozen, up to and including the cycle
// tile_ack is sampled high. The following cycle (DONE) tile_req is low.
//
// Build option DISPATCH_ERRCNT_EN: adds an 8-bit saturating error counter
// (illegal commands + dropped frames) read and cleared by command 0x05.
// Without it, 0x05 is an illegal command.

module npu_cmd_dispatch #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] cmd,
  input  logic [2:0] tile_i,
  input  logic [2:0] tile_j,
  input  logic [2:0] op_code,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       tile_req,
  output logic [1:0] tile_cmd,
  output logic [5:0] tile_addr,
  output logic [2:0] tile_op,
  output logic [7:0] tile_wdata,
  input  logic       tile_ack,
  input  logic [7:0] tile_rdata,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Command FIFO storage and bookkeeping
  logic [24:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [1:0] state;
  logic       ovf;
  logic       err;

  // Head-of-queue fields
  logic [24:0] head;
  logic [7:0]  head_cmd;
  logic [2:0]  head_i;
  logic [2:0]  head_j;
  logic [2:0]  head_op;
  logic [7:0]  head_data;

  assign head      = mem[rd_ptr];
  assign head_cmd  = head[24:17];
  assign head_i    = head[16:14];
  assign head_j    = head[13:11];
  assign head_op   = head[10:8];
  assign head_data = head[7:0];

  logic full;
  logic empty;
  logic pop;
  logic push_ok;
  logic drop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // The FSM only consumes a command while IDLE; NOP/STATUS/illegal are
  // retired in that same cycle.
  assign pop     = (state == S_IDLE) && !empty;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok = valid && (!full || pop);
  assign drop    = valid && full && !pop;

  // Command decode of the head entry
  logic is_nop;
  logic is_txn;
  logic is_status;
  logic is_errcnt;
  logic illegal;
  logic status_clr;

  assign is_nop    = (head_cmd == 8'h00);
  assign is_txn    = (head_cmd == 8'h01) || (head_cmd == 8'h02) || (head_cmd == 8'h03);
  assign is_status = (head_cmd == 8'h04);
`ifdef DISPATCH_ERRCNT_EN
  assign is_errcnt = (head_cmd == 8'h05);
`else
  assign is_errcnt = 1'b0;
`endif
  assign illegal    = pop && !(is_nop || is_txn || is_status || is_errcnt);
  assign status_clr = pop && is_status;

  // STATUS reports how many entries remain queued behind itself.
  logic [AW:0] rem_cnt;
  logic [2:0]  rem3;
  logic [7:0]  status_byte;

  assign rem_cnt     = count - {{AW{1'b0}}, 1'b1};
  assign rem3        = 3'(rem_cnt);
  assign status_byte = {ovf, err, 3'b000, rem3};

  assign tile_req = (state == S_ISSUE);
  assign busy     = !empty || (state != S_IDLE);

  // FIFO storage: no reset needed, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {cmd, tile_i, tile_j, op_code, data_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end
  end

`ifdef DISPATCH_ERRCNT_EN
  logic [7:0] err_cnt;
  logic [1:0] err_inc;
  logic [7:0] err_base;
  logic [8:0] err_sum;

  assign err_inc  = {1'b0, illegal} + {1'b0, drop};
  // Clear happens first so a same-cycle increment survives it.
  assign err_base = (pop && is_errcnt) ? 8'h00 : err_cnt;
  assign err_sum  = {1'b0, err_base} + {7'b0, err_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'h00;
    end else begin
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      data_out   <= 8'h00;
      tile_cmd   <= 2'b00;
      tile_addr  <= 6'd0;
      tile_op    <= 3'd0;
      tile_wdata <= 8'h00;
      ovf        <= 1'b0;
      err        <= 1'b0;
    end else begin
      // A new set in the same cycle as a STATUS clear wins.
      ovf <= (ovf && !status_clr) || drop;
      err <= (err && !status_clr) || illegal;

      case (state)
        S_IDLE: begin
          if (pop) begin
            if (is_txn) begin
              // Commands 1..3 map directly onto the 2-bit tile encoding.
              tile_cmd   <= head_cmd[1:0];
              tile_addr  <= {head_i, head_j};
              tile_op    <= head_op;
              tile_wdata <= head_data;
              state      <= S_ISSUE;
            end else if (is_status) begin
              data_out <= status_byte;
            end
`ifdef DISPATCH_ERRCNT_EN
            else if (is_errcnt) begin
              data_out <= err_cnt;
            end
`endif
          end
        end
        S_ISSUE: begin
          if (tile_ack) begin
            state <= S_DONE;
            if (tile_cmd == 2'b10) data_out <= tile_rdata;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_cmd_dispatch.sv
module tb_npu_cmd_dispatch;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] cmd;
  logic [2:0] tile_i;
  logic [2:0] tile_j;
  logic [2:0] op_code;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       tile_req;
  logic [1:0] tile_cmd;
  logic [5:0] tile_addr;
  logic [2:0] tile_op;
  logic [7:0] tile_wdata;
  logic       tile_ack;
  logic [7:0] tile_rdata;
  logic       busy;

  always #5 clk = ~clk;

  npu_cmd_dispatch #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .valid(valid), .cmd(cmd), .tile_i(tile_i),
    .tile_j(tile_j), .op_code(op_code), .data_in(data_in),
    .data_out(data_out), .tile_req(tile_req), .tile_cmd(tile_cmd),
    .tile_addr(tile_addr), .tile_op(tile_op), .tile_wdata(tile_wdata),
    .tile_ack(tile_ack), .tile_rdata(tile_rdata), .busy(busy)
  );

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;

  // expected tile transactions: {tile_cmd[1:0], addr[5:0], op[2:0], wdata[7:0]}
  logic [18:0] exp_q[$];
  logic [7:0]  model_dout = 8'h00;
  logic        model_err  = 1'b0;
  logic        model_ovf  = 1'b0;
  int          n_txn      = 0;
  int          ack_wait   = 0;
  logic [7:0]  rsp_rdata  = 8'h00;
  bit          rand_rdata = 1'b0;

  typedef struct {
    logic [7:0] c;
    logic [2:0] i;
    logic [2:0] j;
    logic [2:0] op;
    logic [7:0] d;
    logic [7:0] rdata;
    logic [7:0] exp_dout;
    int         exp_txn;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; leaves at the next posedge+1 so calls chain back-to-back.
  task automatic push(input logic [7:0] c, input logic [2:0] i, input logic [2:0] j,
                      input logic [2:0] op, input logic [7:0] d, input bit accepted = 1'b1);
    int legal_max;
`ifdef DISPATCH_ERRCNT_EN
    legal_max = 5;
`else
    legal_max = 4;
`endif
    valid = 1'b1; cmd = c; tile_i = i; tile_j = j; op_code = op; data_in = d;
    if (!accepted) begin
      model_ovf = 1'b1;
    end else begin
      case (c)
        8'h01: exp_q.push_back({2'b01, i, j, op, d});
        8'h02: exp_q.push_back({2'b10, i, j, op, d});
        8'h03: exp_q.push_back({2'b11, i, j, op, d});
        default: if (int'(c) > legal_max) model_err = 1'b1;
      endcase
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Present an ack for the current request and check it against the model.
  task automatic do_ack(input logic [7:0] rd);
    logic [18:0] e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_txn actual_cmd=%0d expected=none", tile_cmd);
    end else begin
      e = exp_q.pop_front();
      chk("txn_cmd", tile_cmd, e[18:17]);
      chk("txn_addr", tile_addr, e[16:11]);
      if (e[18:17] == 2'b11) chk("txn_op", tile_op, e[10:8]);
      if (e[18:17] == 2'b01) chk("txn_wdata", tile_wdata, e[7:0]);
      if (e[18:17] == 2'b10) model_dout = rd;
    end
    tile_rdata = rd;
    tile_ack   = 1'b1;
    n_txn++;
  endtask

  // One cycle of tile-array responder behaviour with a random ack delay.
  task automatic service();
    tile_ack = 1'b0;
    if (tile_req) begin
      if (ack_wait == 0) begin
        do_ack(rand_rdata ? 8'($urandom) : rsp_rdata);
        ack_wait = $urandom_range(0, 3);
      end else begin
        ack_wait--;
      end
    end
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((busy || tile_ack) && cyc < 400) begin
      service();
      @(posedge clk); #1;
      cyc++;
    end
    tile_ack = 1'b0;
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_data_out"}, data_out, 8'h00);
    chk({tag, "_tile_req"}, tile_req, 1'b0);
    chk({tag, "_tile_cmd"}, tile_cmd, 2'b00);
    chk({tag, "_tile_addr"}, tile_addr, 6'd0);
    chk({tag, "_tile_op"}, tile_op, 3'd0);
    chk({tag, "_tile_wdata"}, tile_wdata, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n0;
    int held;
    int seen;

    vecs[0]  = '{8'h01, 3'd2, 3'd5, 3'd0, 8'hA7, 8'h00, 8'h00, 1};
    vecs[1]  = '{8'h02, 3'd7, 3'd7, 3'd0, 8'h00, 8'h3C, 8'h3C, 1};
    vecs[2]  = '{8'h03, 3'd1, 3'd3, 3'd5, 8'h11, 8'h00, 8'h3C, 1};
    vecs[3]  = '{8'h00, 3'd4, 3'd4, 3'd1, 8'h22, 8'h00, 8'h3C, 0};
    vecs[4]  = '{8'h7E, 3'd0, 3'd1, 3'd0, 8'h33, 8'h00, 8'h3C, 0};
    vecs[5]  = '{8'h04, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h40, 0};
    vecs[6]  = '{8'h04, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 0};
    vecs[7]  = '{8'h02, 3'd0, 3'd0, 3'd0, 8'h00, 8'h5A, 8'h5A, 1};
    vecs[8]  = '{8'hFF, 3'd3, 3'd3, 3'd3, 8'h44, 8'h00, 8'h5A, 0};
    vecs[9]  = '{8'h00, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h5A, 0};
    vecs[10] = '{8'h04, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h40, 0};
    vecs[11] = '{8'h06, 3'd5, 3'd2, 3'd0, 8'h00, 8'h00, 8'h40, 0};
    vecs[12] = '{8'h04, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h40, 0};

    rst = 1'b1; valid = 1'b0; cmd = 8'h00; tile_i = 3'd0; tile_j = 3'd0;
    op_code = 3'd0; data_in = 8'h00; tile_ack = 1'b0; tile_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("reset");

    // ---- table-driven single frames ----
    rand_rdata = 1'b0;
    for (int k = 0; k < 13; k++) begin
      n0 = n_txn;
      rsp_rdata = vecs[k].rdata;
      push(vecs[k].c, vecs[k].i, vecs[k].j, vecs[k].op, vecs[k].d);
      wait_idle();
      chk($sformatf("vec%0d_dout", k), data_out, vecs[k].exp_dout);
      chk($sformatf("vec%0d_ntxn", k), n_txn - n0, vecs[k].exp_txn);
    end

    // ---- WRITE timing: req at T+2, fields held, low after ack ----
    push(8'h01, 3'd2, 3'd5, 3'd0, 8'hA7);
    chk("wr_req_T1", tile_req, 1'b0);
    @(posedge clk); #1;
    chk("wr_req_T2", tile_req, 1'b1);
    chk("wr_cmd", tile_cmd, 2'b01);
    chk("wr_addr", tile_addr, 6'h15);
    chk("wr_wdata", tile_wdata, 8'hA7);
    repeat (2) begin @(posedge clk); #1; end
    chk("wr_req_held", tile_req, 1'b1);
    chk("wr_wdata_held", tile_wdata, 8'hA7);
    do_ack(8'h00);
    @(posedge clk); #1;
    tile_ack = 1'b0;
    chk("wr_req_done", tile_req, 1'b0);
    wait_idle();

    // ---- READ with ack delayed 5 cycles ----
    push(8'h02, 3'd7, 3'd7, 3'd0, 8'h00);
    @(posedge clk); #1;
    held = 0;
    for (int k = 0; k < 5; k++) begin
      if (tile_req) held++;
      @(posedge clk); #1;
    end
    chk("rd_req_held", held, 5);
    chk("rd_addr", tile_addr, 6'h3F);
    do_ack(8'h3C);
    @(posedge clk); #1;
    tile_ack = 1'b0;
    chk("rd_dout", data_out, 8'h3C);
    chk("rd_req_done", tile_req, 1'b0);
    wait_idle();

    // ---- overflow: 6 back-to-back frames, ack withheld ----
    push(8'h01, 3'd1, 3'd1, 3'd0, 8'h01);
    push(8'h01, 3'd1, 3'd2, 3'd0, 8'h02);
    push(8'h04, 3'd0, 3'd0, 3'd0, 8'h00);
    push(8'h01, 3'd1, 3'd3, 3'd0, 8'h03);
    push(8'h01, 3'd1, 3'd4, 3'd0, 8'h04);
    push(8'h01, 3'd1, 3'd5, 3'd0, 8'h05, 1'b0);
    chk("ovf_req", tile_req, 1'b1);
    chk("ovf_busy", busy, 1'b1);
    n0 = n_txn;
    rand_rdata = 1'b1;
    wait_idle();
    // STATUS saw itself plus two WRITEs queued and the sticky overflow
    chk("ovf_status", data_out, 8'h82);
    chk("ovf_ntxn", n_txn - n0, 4);
    push(8'h04, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_idle();
    chk("ovf_cleared", data_out, 8'h00);

    // ---- error counter / command 0x05 ----
`ifdef DISPATCH_ERRCNT_EN
    for (int k = 0; k < 300; k++) push(8'h80, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_idle();
    push(8'h05, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_idle();
    chk("errcnt_sat", data_out, 8'hFF);
    push(8'h05, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_idle();
    chk("errcnt_clr", data_out, 8'h00);
    push(8'h04, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_idle();
    chk("errcnt_err", data_out, 8'h40);
`else
    push(8'h05, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_idle();
    push(8'h04, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_idle();
    chk("cmd05_illegal", data_out, 8'h40);
`endif

    // ---- reset mid-transaction with 3 entries queued ----
    for (int k = 0; k < 4; k++) push(8'h01, 3'd2, 3'(k), 3'd0, 8'h10);
    chk("mid_req", tile_req, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_values("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_dout = 8'h00; model_err = 1'b0; model_ovf = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (tile_req || busy) seen++;
    end
    chk("no_req_after_rst", seen, 0);

    // ---- randomized bursts against the model ----
    rand_rdata = 1'b1;
    for (int b = 0; b < 40; b++) begin
      int nf;
      logic [7:0] exp_status;
      nf = $urandom_range(1, 4);
      for (int k = 0; k < nf; k++) begin
        int kind;
        logic [7:0] c;
        kind = $urandom_range(0, 4);
        c = (kind < 4) ? 8'(kind) : 8'($urandom_range(6, 255));
        push(c, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
      end
      wait_idle();
      chk($sformatf("rand%0d_dout", b), data_out, model_dout);
      if (b % 2 == 0) begin
        exp_status = {model_ovf, model_err, 6'b000000};
        push(8'h04, 3'd0, 3'd0, 3'd0, 8'h00);
        wait_idle();
        chk($sformatf("rand%0d_status", b), data_out, exp_status);
        model_err = 1'b0; model_ovf = 1'b0; model_dout = exp_status;
      end
    end
    chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
